// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS core data port: word RAM with one-cycle
// registered read, post-reset clear sequencer, preload port and sticky store-error flags.
module data_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_rd_wr,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_out,
    output logic [31:0]      data_in,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_data,
    output logic             init_busy,
    output logic             err_range,
    output logic             err_align,
    input  logic             err_clr
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_in_q, data_in_d;
    logic             err_range_q, err_range_d;
    logic             err_align_q, err_align_d;

    logic [31:0]      mem_q [DEPTH];

    logic [31:0]      off;
    logic             in_range;
    logic             aligned;
    logic [IDX_W-1:0] idx;

    logic             ready;
    logic             st_req;
    logic             st_ok;
    logic             set_range;
    logic             set_align;

    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [31:0]      wdata;

    // BASE_ADDR is word aligned, so the low offset bits equal the low address bits.
    always_comb begin
        off      = data_addr - BASE_ADDR;
        in_range = (data_addr >= BASE_ADDR) && ({2'b00, off[31:2]} < 32'(DEPTH));
        idx      = off[IDX_W+1:2];
        aligned  = (off[1:0] == 2'b00);
    end

    // A preload in the same cycle silently swallows any core store.
    always_comb begin
        ready     = (state_q == ST_READY);
        st_req    = ready && !data_rd_wr && !load_en;
        st_ok     = st_req && in_range && aligned;
        set_range = st_req && !in_range;
        set_align = st_req && in_range && !aligned;
    end

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state_q == ST_INIT) begin
            we    = 1'b1;
            waddr = cnt_q;
        end else if (load_en) begin
            we    = 1'b1;
            waddr = load_idx;
            wdata = load_data;
        end else if (st_ok) begin
            we    = 1'b1;
            waddr = idx;
            wdata = data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_in_d   = data_in_q;
        err_range_d = (err_range_q && !err_clr) || set_range;
        err_align_d = (err_align_q && !err_clr) || set_align;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (data_rd_wr) begin
                    data_in_d = in_range ? mem_q[idx] : '0;
                end else if (st_ok) begin
                    data_in_d = data_out;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            data_in_q   <= '0;
            err_range_q <= 1'b0;
            err_align_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_in_q   <= data_in_d;
            err_range_q <= err_range_d;
            err_align_q <= err_align_d;
        end
    end

    assign data_in   = data_in_q;
    assign init_busy = (state_q == ST_INIT);
    assign err_range = err_range_q;
    assign err_align = err_align_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps plus random traffic
// compared against an array-based behavioural model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned IW    = 4;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          data_rd_wr = 1'b1;
    logic [31:0]   data_addr  = '0;
    logic [31:0]   data_out   = '0;
    logic [31:0]   data_in;
    logic          load_en    = 1'b0;
    logic [IW-1:0] load_idx   = '0;
    logic [31:0]   load_data  = '0;
    logic          init_busy;
    logic          err_range;
    logic          err_align;
    logic          err_clr    = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_din;
    logic        m_er;
    logic        m_ea;
    int          m_init_left;

    data_mem_responder #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_rd_wr(data_rd_wr),
        .data_addr (data_addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data),
        .init_busy (init_busy),
        .err_range (err_range),
        .err_align (err_align),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_in"},   data_in,               m_din);
        check({tag, ".err_range"}, {31'b0, err_range},    {31'b0, m_er});
        check({tag, ".err_align"}, {31'b0, err_align},    {31'b0, m_ea});
        check({tag, ".init_busy"}, {31'b0, init_busy},    {31'b0, (m_init_left > 0)});
    endtask

    // One clock of stimulus; the model is advanced from the rules, then all outputs compared.
    task automatic step(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input logic le, input logic [IW-1:0] li, input logic [31:0] ld,
                        input logic clr, input string tag);
        logic inr;
        int   widx;
        logic sr;
        logic sa;
        data_rd_wr = rw;
        data_addr  = a;
        data_out   = d;
        load_en    = le;
        load_idx   = li;
        load_data  = ld;
        err_clr    = clr;
        sr = 1'b0;
        sa = 1'b0;
        if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            inr  = (a >= BASE) && ((a - BASE) < DEPTH * 4);
            widx = inr ? int'((a - BASE) / 4) : 0;
            if (rw) begin
                m_din = inr ? m_mem[widx] : 32'h0;
            end else if (!le) begin
                if (!inr)            sr = 1'b1;
                else if (a % 4 != 0) sa = 1'b1;
                else begin
                    m_mem[widx] = d;
                    m_din       = d;
                end
            end
            if (le) m_mem[li] = ld;
            m_er = (m_er && !clr) || sr;
            m_ea = (m_ea && !clr) || sa;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        m_din = '0;
        m_er  = 1'b0;
        m_ea  = 1'b0;
        m_init_left = DEPTH;
        #1;
        check_all({tag, ".async"});
        repeat (3) @(posedge clk);
        #1;
        check_all({tag, ".hold"});
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        reset = 1'b1;
    endtask

    task automatic rand_step(input string tag);
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else                           a = BASE - 32'd8 + 32'($urandom_range(0, 'h50));
        step(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 4) == 0),
             IW'($urandom), $urandom, ($urandom_range(0, 7) == 0), tag);
    endtask

    task automatic init_steps(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'(i % 2), BASE + 32'(4 * i) + ((i % 5 == 0) ? 32'h40 : 32'h0) + 32'(i % 3),
                 32'hF0F0_0000 | 32'(i), (i % 3 == 0), IW'(i), ~32'(i), 1'b0, tag);
        end
        check({tag, ".done"}, {31'b0, init_busy}, 32'h0);
    endtask

    initial begin
        #2;
        do_reset("rst0");
        init_steps("init0");

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, BASE + 32'(4 * i), 32'h0, 1'b0, '0, '0, 1'b0, "rd_clear");
            check("rd_clear.zero", data_in, 32'h0);
        end

        step(1'b0, BASE + 32'h8, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, "st_db");
        check("st_db.write_first", data_in, 32'hDEAD_BEEF);
        step(1'b1, BASE + 32'h8, 32'h0, 1'b0, '0, '0, 1'b0, "rd_db");
        check("rd_db.value", data_in, 32'hDEAD_BEEF);

        step(1'b0, BASE + 32'h40, 32'h1357_9BDF, 1'b0, '0, '0, 1'b0, "st_oor");
        check("st_oor.flag", {31'b0, err_range}, 32'h1);
        step(1'b1, BASE - 32'h4, 32'h0, 1'b0, '0, '0, 1'b0, "rd_below");
        check("rd_below.zero", data_in, 32'h0);
        step(1'b1, BASE + 32'h40, 32'h0, 1'b0, '0, '0, 1'b0, "rd_above");
        step(1'b1, BASE + 32'h8, 32'h0, 1'b0, '0, '0, 1'b1, "clr");
        check("clr.flag", {31'b0, err_range}, 32'h0);

        step(1'b0, BASE + 32'h4, 32'h0101_0101, 1'b0, '0, '0, 1'b0, "st_w1");
        step(1'b0, BASE + 32'h6, 32'h1234_5678, 1'b0, '0, '0, 1'b0, "st_unal");
        check("st_unal.flag", {31'b0, err_align}, 32'h1);
        step(1'b1, BASE + 32'h6, 32'h0, 1'b0, '0, '0, 1'b0, "rd_unal");
        check("rd_unal.value", data_in, 32'h0101_0101);

        step(1'b0, BASE + 32'h80, 32'h0, 1'b0, '0, '0, 1'b0, "set_er");
        step(1'b0, BASE + 32'h2, 32'h0, 1'b0, '0, '0, 1'b1, "clr_vs_set");
        check("clr_vs_set.align", {31'b0, err_align}, 32'h1);
        check("clr_vs_set.range", {31'b0, err_range}, 32'h0);
        step(1'b1, BASE, 32'h0, 1'b0, '0, '0, 1'b1, "clr2");

        step(1'b1, BASE + 32'h8, 32'h0, 1'b0, '0, '0, 1'b0, "pre_ld");
        step(1'b0, BASE + 32'h8, 32'h5555_5555, 1'b1, IW'(2), 32'hAAAA_0000, 1'b0, "ld_vs_st");
        check("ld_vs_st.din", data_in, 32'hDEAD_BEEF);
        step(1'b1, BASE + 32'h8, 32'h0, 1'b1, IW'(2), 32'h7777_7777, 1'b0, "ld_vs_rd");
        check("ld_vs_rd.old", data_in, 32'hAAAA_0000);
        step(1'b1, BASE + 32'h8, 32'h0, 1'b0, '0, '0, 1'b0, "rd_ld");
        check("rd_ld.new", data_in, 32'h7777_7777);
        step(1'b0, BASE + 32'h8, 32'h2468_ACE0, 1'b0, '0, '0, 1'b0, "st_w2");
        step(1'b1, BASE + 32'h8, 32'h0, 1'b0, '0, '0, 1'b0, "raw_w2");

        for (int i = 0; i < 400; i++) rand_step("rand1");

        step(1'b0, BASE + 32'h4, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b0, "st_cafe");
        do_reset("rst1");
        init_steps("init1");
        step(1'b1, BASE + 32'h4, 32'h0, 1'b0, '0, '0, 1'b0, "rd_after_rst");
        check("rd_after_rst.zero", data_in, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, BASE + 32'(4 * i), 32'h0, 1'b0, '0, '0, 1'b0, "rd_clear1");
        end

        for (int i = 0; i < 300; i++) rand_step("rand2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
